// File: rtl/intc_defs.sv
// Shared definitions for the interrupt controller: CSR byte offsets and field positions.
package intc_defs;

   // Width of a claim id (source index + 1, 0 meaning "none")
   localparam int unsigned IdWidth = 5;
   typedef logic [IdWidth-1:0] irq_id_t;

   // CSR byte offsets
   localparam int unsigned OffPending = 32'h00;
   localparam int unsigned OffEnable  = 32'h04;
   localparam int unsigned OffMode    = 32'h08;
   localparam int unsigned OffActive  = 32'h0C;
   localparam int unsigned OffClaim   = 32'h10;
   localparam int unsigned OffCtrl    = 32'h14;

   // CTRL register fields
   localparam int unsigned CtrlGenBit = 0;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder: returns index+1 of the lowest set bit, 0 if empty.
module intc_prio_enc
   import intc_defs::*;
#(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0] req,
   output irq_id_t            id
);

   // Scan from the top down so the lowest set bit is the last assignment and wins
   always_comb begin
      id = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (req[i]) id = irq_id_t'(i + 1);
      end
   end

endmodule

// File: rtl/intc_core.sv
// Interrupt controller core: per-source edge/level pending capture, enable masking,
// global gate, lowest-index claim, and a registered interrupt request to the CPU.
module intc_core
   import intc_defs::*;
#(
   parameter int unsigned NUM_IRQ   = 8,
   parameter int unsigned ADD_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [ADD_WIDTH-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   input  logic                 rden,
   input  logic                 wren,
   input  logic [NUM_IRQ-1:0]   irq_src,
   output logic                 irq
);

   logic [NUM_IRQ-1:0] prev_q, pending_q, pending_d, enable_q, mode_q;
   logic [NUM_IRQ-1:0] rise, active, gated, w1c, claim_clr;
   logic               gen_q, irq_q, irq_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [ADD_WIDTH-1:0] word_addr;
   logic               hit_pending, hit_enable, hit_mode, hit_active, hit_claim, hit_ctrl;
   logic               claim_rd;
   irq_id_t            claim_id;
   logic               unused_wdata;

   // Byte-lane bits of the address are don't-care; mask them off for word decode
   assign word_addr   = addr & ~ADD_WIDTH'(3);
   assign hit_pending = (word_addr == ADD_WIDTH'(OffPending));
   assign hit_enable  = (word_addr == ADD_WIDTH'(OffEnable));
   assign hit_mode    = (word_addr == ADD_WIDTH'(OffMode));
   assign hit_active  = (word_addr == ADD_WIDTH'(OffActive));
   assign hit_claim   = (word_addr == ADD_WIDTH'(OffClaim));
   assign hit_ctrl    = (word_addr == ADD_WIDTH'(OffCtrl));

   assign unused_wdata = ^wdata[31:NUM_IRQ];

   assign rise     = irq_src & ~prev_q;
   assign active   = pending_q & enable_q;
   // With the global gate off, CLAIM sees nothing and clears nothing
   assign gated    = active & {NUM_IRQ{gen_q}};
   assign claim_rd = rden & hit_claim;
   assign w1c      = (wren && hit_pending) ? wdata[NUM_IRQ-1:0] : '0;

   intc_prio_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio_enc (
      .req (gated),
      .id  (claim_id)
   );

   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_pend
      assign claim_clr[i] = claim_rd && (claim_id == irq_id_t'(i + 1));

      // Edge bits: a new rise beats any same-cycle clear. Level bits just track the line.
      always_comb begin
         if (mode_q[i]) begin
            pending_d[i] = rise[i] | (pending_q[i] & ~(w1c[i] | claim_clr[i]));
         end else begin
            pending_d[i] = irq_src[i];
         end
      end
   end

   assign irq_d = gen_q & |active;

   // Read mux samples pre-write state so a same-cycle write is not visible
   always_comb begin
      rdata_d = rdata_q;
      if (rden) begin
         if (hit_pending)     rdata_d = 32'(pending_q);
         else if (hit_enable) rdata_d = 32'(enable_q);
         else if (hit_mode)   rdata_d = 32'(mode_q);
         else if (hit_active) rdata_d = 32'(active);
         else if (hit_claim)  rdata_d = 32'(claim_id);
         else if (hit_ctrl)   rdata_d = 32'(gen_q);
         else                 rdata_d = '0;
      end
   end

   // State registers: edge history, pending, CSRs, read data and irq
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q    <= '0;
         pending_q <= '0;
         enable_q  <= '0;
         mode_q    <= '0;
         gen_q     <= 1'b0;
         irq_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         prev_q    <= irq_src;
         pending_q <= pending_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
         if (wren && hit_enable) enable_q <= wdata[NUM_IRQ-1:0];
         if (wren && hit_mode)   mode_q   <= wdata[NUM_IRQ-1:0];
         if (wren && hit_ctrl)   gen_q    <= wdata[CtrlGenBit];
      end
   end

   assign rdata = rdata_q;
   assign irq   = irq_q;

endmodule

// File: tb/tb_intc_core.sv
// Self-checking bench for intc_core: directed scenarios plus a randomized run
// against a bit-level behavioural model of the register map.
module tb_intc_core;

   localparam int unsigned NUM = 8;
   localparam logic [31:0] MASK = 32'h0000_00FF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        rden = 1'b0;
   logic        wren = 1'b0;
   logic [NUM-1:0] irq_src = '0;
   logic        irq;

   int checks = 0;
   int failures = 0;

   intc_core #(
      .NUM_IRQ   (NUM),
      .ADD_WIDTH (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .rden    (rden),
      .wren    (wren),
      .irq_src (irq_src),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      rden = 1'b0;
      wren = 1'b0;
      irq_src = '0;
      addr = '0;
      wdata = '0;
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      step();
   endtask

   task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
      addr = a;
      wdata = d;
      wren = 1'b1;
      step();
      wren = 1'b0;
   endtask

   task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
      addr = a;
      rden = 1'b1;
      step();
      rden = 1'b0;
      d = rdata;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      do_reset();
      checks++;
      if (irq !== 1'b0 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs irq=%b rdata=%h want irq=0 rdata=0", irq, rdata);
      end
      for (int i = 0; i < 6; i++) begin
         csr_read(8'(i * 4), v);
         checks++;
         if (v !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_read off=%h got=%h irq=%b want 0", i * 4, v, irq);
         end
      end
      csr_write(8'h18, 32'hFFFF_FFFF);
      csr_read(8'h18, v);
      checks++;
      if (v !== 32'h0) begin
         failures++;
         $display("FAIL unmapped_read got=%h want 0", v);
      end
   endtask

   task automatic test_edge();
      logic [31:0] v;
      do_reset();
      csr_write(8'h04, 32'h01);
      csr_write(8'h08, 32'h01);
      csr_write(8'h14, 32'h01);
      irq_src[0] = 1'b1;
      step();
      irq_src[0] = 1'b0;
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL edge_irq_n got=%b want 0", irq);
      end
      step();
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL edge_irq_n1 got=%b want 1", irq);
      end
      csr_read(8'h00, v);
      checks++;
      if (v !== 32'h01) begin
         failures++;
         $display("FAIL edge_pending got=%h want 01", v);
      end
      csr_read(8'h10, v);
      checks++;
      if (v !== 32'd1 || irq !== 1'b1) begin
         failures++;
         $display("FAIL edge_claim got=%h irq=%b want 1 irq=1", v, irq);
      end
      step();
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL edge_irq_after_claim got=%b want 0", irq);
      end
      csr_read(8'h00, v);
      checks++;
      if (v !== 32'h0) begin
         failures++;
         $display("FAIL edge_pending_cleared got=%h want 0", v);
      end
   endtask

   task automatic test_level();
      logic [31:0] v;
      do_reset();
      csr_write(8'h08, 32'h00);
      csr_write(8'h04, 32'h04);
      csr_write(8'h14, 32'h01);
      irq_src[2] = 1'b1;
      step();
      step();
      for (int k = 0; k < 2; k++) begin
         csr_read(8'h10, v);
         checks++;
         if (v !== 32'd3) begin
            failures++;
            $display("FAIL level_claim%0d got=%h want 3", k, v);
         end
      end
      csr_write(8'h00, 32'h04);
      csr_read(8'h00, v);
      checks++;
      if (v !== 32'h04) begin
         failures++;
         $display("FAIL level_w1c got=%h want 04", v);
      end
      irq_src[2] = 1'b0;
      step();
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL level_drop_irq got=%b want 1", irq);
      end
      step();
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL level_drop_irq2 got=%b want 0", irq);
      end
      csr_read(8'h00, v);
      checks++;
      if (v !== 32'h0) begin
         failures++;
         $display("FAIL level_pending got=%h want 0", v);
      end
   endtask

   task automatic test_priority();
      logic [31:0] v;
      logic [31:0] exp_claim [3];
      exp_claim = '{32'd4, 32'd6, 32'd0};
      do_reset();
      csr_write(8'h08, 32'h2A);
      csr_write(8'h04, 32'h28);
      csr_write(8'h14, 32'h01);
      irq_src = 8'h2A;
      step();
      irq_src = '0;
      step();
      csr_read(8'h0C, v);
      checks++;
      if (v !== 32'h28) begin
         failures++;
         $display("FAIL prio_active got=%h want 28", v);
      end
      for (int k = 0; k < 3; k++) begin
         csr_read(8'h10, v);
         checks++;
         if (v !== exp_claim[k]) begin
            failures++;
            $display("FAIL prio_claim%0d got=%h want %h", k, v, exp_claim[k]);
         end
      end
      csr_read(8'h00, v);
      checks++;
      if (v !== 32'h02 || irq !== 1'b0) begin
         failures++;
         $display("FAIL prio_residual got=%h irq=%b want 02 irq=0", v, irq);
      end
   endtask

   task automatic test_collision();
      logic [31:0] v;
      do_reset();
      csr_write(8'h08, 32'h01);
      csr_write(8'h04, 32'h01);
      csr_write(8'h14, 32'h01);
      irq_src[0] = 1'b1;
      step();
      irq_src[0] = 1'b0;
      step();
      // W1C of bit0 in the same cycle as a fresh rise
      addr = 8'h00;
      wdata = 32'h01;
      wren = 1'b1;
      irq_src[0] = 1'b1;
      step();
      wren = 1'b0;
      irq_src[0] = 1'b0;
      csr_read(8'h00, v);
      checks++;
      if (v !== 32'h01) begin
         failures++;
         $display("FAIL coll_w1c got=%h want 01", v);
      end
      // CLAIM read in the same cycle as a fresh rise
      addr = 8'h10;
      rden = 1'b1;
      irq_src[0] = 1'b1;
      step();
      rden = 1'b0;
      irq_src[0] = 1'b0;
      checks++;
      if (rdata !== 32'd1) begin
         failures++;
         $display("FAIL coll_claim got=%h want 1", rdata);
      end
      csr_read(8'h00, v);
      checks++;
      if (v !== 32'h01) begin
         failures++;
         $display("FAIL coll_claim_pending got=%h want 01", v);
      end
   endtask

   task automatic test_gate_and_reset();
      logic [31:0] v;
      do_reset();
      csr_write(8'h08, 32'h01);
      csr_write(8'h04, 32'h01);
      irq_src[0] = 1'b1;
      step();
      irq_src[0] = 1'b0;
      step();
      step();
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL gate_irq_off got=%b want 0", irq);
      end
      csr_read(8'h10, v);
      checks++;
      if (v !== 32'h0) begin
         failures++;
         $display("FAIL gate_claim got=%h want 0", v);
      end
      csr_write(8'h14, 32'h01);
      step();
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL gate_irq_on got=%b want 1", irq);
      end
      csr_read(8'h04, v);
      // Asynchronous reset in the middle of a cycle
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (irq !== 1'b0 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL async_reset irq=%b rdata=%h want 0/0", irq, rdata);
      end
      @(negedge clk);
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         csr_read(8'(i * 4), v);
         checks++;
         if (v !== 32'h0) begin
            failures++;
            $display("FAIL post_reset off=%h got=%h want 0", i * 4, v);
         end
      end
   endtask

   function automatic logic [31:0] lowest_id(input logic [31:0] act);
      for (int i = 0; i < int'(NUM); i++) begin
         if (act[i]) return 32'(i + 1);
      end
      return 32'h0;
   endfunction

   task automatic test_random();
      logic [31:0] m_pend, m_en, m_mode, m_prev, m_rdata, act, cl, nxt;
      logic        m_gen, m_irq;
      logic [31:0] a, d, src;
      logic        rd, wr;
      int          op;
      do_reset();
      m_pend = '0; m_en = '0; m_mode = '0; m_prev = '0; m_rdata = '0;
      m_gen = 1'b0; m_irq = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         src = $urandom & MASK;
         op  = int'($urandom_range(0, 3));
         rd  = (op == 1) || (op == 3);
         wr  = (op == 2) || (op == 3);
         a   = 32'($urandom_range(0, 6) * 4 + $urandom_range(0, 3));
         d   = $urandom;
         irq_src = src[NUM-1:0];
         addr = a[7:0];
         wdata = d;
         rden = rd;
         wren = wr;
         // Model: everything seen this cycle uses the state from before the edge
         act = m_pend & m_en;
         cl  = m_gen ? lowest_id(act) : 32'h0;
         if (rd) begin
            case (a >> 2)
               0: m_rdata = m_pend;
               1: m_rdata = m_en;
               2: m_rdata = m_mode;
               3: m_rdata = act;
               4: m_rdata = cl;
               5: m_rdata = {31'b0, m_gen};
               default: m_rdata = 32'h0;
            endcase
         end
         for (int i = 0; i < int'(NUM); i++) begin
            if (!m_mode[i]) nxt[i] = src[i];
            else if (src[i] && !m_prev[i]) nxt[i] = 1'b1;
            else if ((wr && (a >> 2) == 0 && d[i]) || (rd && (a >> 2) == 4 && cl == 32'(i + 1)))
               nxt[i] = 1'b0;
            else nxt[i] = m_pend[i];
         end
         nxt[31:NUM] = '0;
         m_irq = m_gen && (act != 0);
         if (wr) begin
            case (a >> 2)
               1: m_en = d & MASK;
               2: m_mode = d & MASK;
               5: m_gen = d[0];
               default: ;
            endcase
         end
         m_pend = nxt;
         m_prev = src;
         step();
         checks++;
         if (rdata !== m_rdata || irq !== m_irq) begin
            failures++;
            $display("FAIL rand_cyc%0d rdata=%h irq=%b want rdata=%h irq=%b",
                     cyc, rdata, irq, m_rdata, m_irq);
         end
      end
      rden = 1'b0;
      wren = 1'b0;
      irq_src = '0;
   endtask

   initial begin
      test_reset();
      test_edge();
      test_level();
      test_priority();
      test_collision();
      test_gate_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
